// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter/sequencer shared by fetch (F) and memory stage (MEM).
// MEM has priority; a starvation counter forces an F win; one read outstanding at a time.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 F_req,
  input  logic [ADDR_SIZE-1:0] F_addr,
  output logic                 F_gnt,
  output logic                 F_rvalid,
  output logic [XLEN-1:0]      F_rdata,

  input  logic                 MEM_req,
  input  logic                 MEM_we,
  input  logic [ADDR_SIZE-1:0] MEM_addr,
  input  logic [XLEN-1:0]      MEM_wdata,
  output logic                 MEM_gnt,
  output logic                 MEM_rvalid,
  output logic [XLEN-1:0]      MEM_rdata,

  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic [ST_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic             own_f, own_f_nxt;

  logic             f_win;
  logic             mem_win;
  logic             rd_grant;
  logic             capture;

  // Arbitration is purely combinational and only legal in IDLE; rst masks every grant.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    f_win   = 1'b0;
    mem_win = 1'b0;
    if (!rst && state == IDLE) begin
      if (F_req && MEM_req) begin
        if (starve_cnt == ST_W'(STARVE_MAX)) f_win   = 1'b1;
        else                                 mem_win = 1'b1;
      end else begin
        f_win   = F_req;
        mem_win = MEM_req;
      end
    end
  end

  assign F_gnt    = f_win;
  assign MEM_gnt  = mem_win;
  assign mem_en   = f_win | mem_win;
  assign mem_we   = MEM_we & mem_win;
  assign rd_grant = f_win | (mem_win & ~MEM_we);
  assign capture  = (state == BUSY) && (lat_cnt == LAT_W'(1));

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_win)        mem_addr = F_addr;
    else if (mem_win) mem_addr = MEM_addr;
    if (mem_en)       mem_wdata = MEM_wdata;
  end

  // Next-state logic for the port sequencer and the starvation counter.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    own_f_nxt      = own_f;
    starve_cnt_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (rd_grant) begin
          state_nxt   = BUSY;
          lat_cnt_nxt = LAT_W'(MEM_LAT);
          own_f_nxt   = f_win;
        end
        if (f_win) begin
          starve_cnt_nxt = '0;
        end else if (F_req && starve_cnt != ST_W'(STARVE_MAX)) begin
          starve_cnt_nxt = starve_cnt + ST_W'(1);
        end
      end
      BUSY: begin
        lat_cnt_nxt = lat_cnt - LAT_W'(1);
        if (capture) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_f      <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      own_f      <= own_f_nxt;
    end
  end

  // Read return: capture into the owner's register; rdata holds until that side's next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_rvalid   <= 1'b0;
      MEM_rvalid <= 1'b0;
      F_rdata    <= '0;
      MEM_rdata  <= '0;
    end else begin
      F_rvalid   <= capture & own_f;
      MEM_rvalid <= capture & ~own_f;
      if (capture && own_f)  F_rdata   <= mem_rdata;
      if (capture && !own_f) MEM_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected commands/read returns,
// a negedge monitor pops and compares whenever the DUT issues a command or an rvalid.
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int ADDR_SIZE  = 5;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  bit                   clk;
  logic                 rst;
  logic                 F_req;
  logic [ADDR_SIZE-1:0] F_addr;
  logic                 F_gnt;
  logic                 F_rvalid;
  logic [XLEN-1:0]      F_rdata;
  logic                 MEM_req;
  logic                 MEM_we;
  logic [ADDR_SIZE-1:0] MEM_addr;
  logic [XLEN-1:0]      MEM_wdata;
  logic                 MEM_gnt;
  logic                 MEM_rvalid;
  logic [XLEN-1:0]      MEM_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [XLEN-1:0]      mem_rdata;

  mem_port_arbiter #(
    .XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .F_req(F_req), .F_addr(F_addr), .F_gnt(F_gnt), .F_rvalid(F_rvalid), .F_rdata(F_rdata),
    .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
    .MEM_gnt(MEM_gnt), .MEM_rvalid(MEM_rvalid), .MEM_rdata(MEM_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten words read as 0xC0DE0000|addr (addr 5 holds 0xDEADBEEF);
  // cycles without a read return a poison word so a mistimed capture is visible.
  bit [31:0]     written;
  bit [XLEN-1:0] wr_data [32];
  bit [XLEN-1:0] rd_pipe [MEM_LAT];

  function automatic logic [XLEN-1:0] mem_word(input logic [ADDR_SIZE-1:0] a);
    if (written[a])       return wr_data[a];
    else if (a == 5'd5)   return 32'hDEAD_BEEF;
    else                  return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      written[mem_addr] <= 1'b1;
      wr_data[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : (32'hBAD0_0000 | 32'(cyc));
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  typedef struct {
    int                   cyc;
    bit                   is_f;
    bit                   we;
    logic [ADDR_SIZE-1:0] addr;
    logic [XLEN-1:0]      wdata;
  } cmd_t;

  typedef struct {
    int              cyc;
    logic [XLEN-1:0] data;
  } rd_t;

  cmd_t exp_cmd [$];
  rd_t  exp_f   [$];
  rd_t  exp_m   [$];

  int errors;
  int checks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_cmd(input int c, input bit is_f, input bit we,
                          input logic [ADDR_SIZE-1:0] a, input logic [XLEN-1:0] wd);
    cmd_t e;
    e.cyc = c; e.is_f = is_f; e.we = we; e.addr = a; e.wdata = wd;
    exp_cmd.push_back(e);
  endtask

  task automatic push_f(input int c, input logic [XLEN-1:0] d);
    rd_t e;
    e.cyc = c; e.data = d;
    exp_f.push_back(e);
  endtask

  task automatic push_m(input int c, input logic [XLEN-1:0] d);
    rd_t e;
    e.cyc = c; e.data = d;
    exp_m.push_back(e);
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
  endtask

  cmd_t mon_c;
  rd_t  mon_r;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_strobes", 64'({F_gnt, MEM_gnt, mem_en, mem_we, F_rvalid, MEM_rvalid}), 64'h0);
      check("rst_rdata", {F_rdata, MEM_rdata}, 64'h0);
    end else begin
      if (mem_en || F_gnt || MEM_gnt) begin
        if (exp_cmd.size() == 0) unexpected("cmd");
        else begin
          mon_c = exp_cmd.pop_front();
          check("cmd_cycle", 64'(cyc), 64'(mon_c.cyc));
          check("cmd_owner", 64'({mem_en, F_gnt, MEM_gnt}), 64'({1'b1, mon_c.is_f, ~mon_c.is_f}));
          check("cmd_we", 64'(mem_we), 64'(mon_c.we));
          check("cmd_addr", 64'(mem_addr), 64'(mon_c.addr));
          if (mon_c.we) check("cmd_wdata", 64'(mem_wdata), 64'(mon_c.wdata));
        end
      end
      if (F_rvalid) begin
        if (exp_f.size() == 0) unexpected("f_rvalid");
        else begin
          mon_r = exp_f.pop_front();
          check("f_rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          check("f_rdata", 64'(F_rdata), 64'(mon_r.data));
        end
      end
      if (MEM_rvalid) begin
        if (exp_m.size() == 0) unexpected("mem_rvalid");
        else begin
          mon_r = exp_m.pop_front();
          check("mem_rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          check("mem_rdata", 64'(MEM_rdata), 64'(mon_r.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 5000 cycles");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    F_req = 1'b1;  F_addr = '0;
    MEM_req = 1'b1; MEM_we = 1'b1; MEM_addr = '0; MEM_wdata = '0;
    step();
    step();
    rst = 1'b0; F_req = 1'b0; MEM_req = 1'b0; MEM_we = 1'b0;

    // F read only: grant at t, rvalid at t+3
    step(); t = cyc;
    F_req = 1'b1; F_addr = 5'd5;
    push_cmd(t, 1'b1, 1'b0, 5'd5, '0);
    push_f(t + 3, 32'hDEAD_BEEF);
    step(); F_req = 1'b0;
    repeat (4) step();

    // Simultaneous reads: MEM first, F when the port frees up
    step(); t = cyc;
    F_req = 1'b1; F_addr = 5'd3;
    MEM_req = 1'b1; MEM_we = 1'b0; MEM_addr = 5'd9;
    push_cmd(t, 1'b0, 1'b0, 5'd9, '0);
    push_m(t + 3, 32'hC0DE_0009);
    push_cmd(t + 3, 1'b1, 1'b0, 5'd3, '0);
    push_f(t + 6, 32'hC0DE_0003);
    step(); MEM_req = 1'b0;
    step(); step();
    step(); F_req = 1'b0;
    repeat (3) step();

    // Starvation: three MEM writes, then F forced, then MEM again once IDLE
    step(); t = cyc;
    F_req = 1'b1; F_addr = 5'd10;
    MEM_req = 1'b1; MEM_we = 1'b1; MEM_addr = 5'd20; MEM_wdata = 32'h5000_0020;
    push_cmd(t, 1'b0, 1'b1, 5'd20, 32'h5000_0020);
    step(); MEM_addr = 5'd21; MEM_wdata = 32'h5000_0021;
    push_cmd(t + 1, 1'b0, 1'b1, 5'd21, 32'h5000_0021);
    step(); MEM_addr = 5'd22; MEM_wdata = 32'h5000_0022;
    push_cmd(t + 2, 1'b0, 1'b1, 5'd22, 32'h5000_0022);
    step(); MEM_addr = 5'd23; MEM_wdata = 32'h5000_0023;
    push_cmd(t + 3, 1'b1, 1'b0, 5'd10, '0);
    push_f(t + 6, 32'hC0DE_000A);
    push_cmd(t + 6, 1'b0, 1'b1, 5'd23, 32'h5000_0023);
    step(); F_addr = 5'd11;
    step(); step();
    step(); MEM_req = 1'b0;
    push_cmd(t + 7, 1'b1, 1'b0, 5'd11, '0);
    push_f(t + 10, 32'hC0DE_000B);
    step(); F_req = 1'b0;
    repeat (3) step();

    // Write then read of the same address in consecutive cycles
    step(); t = cyc;
    MEM_req = 1'b1; MEM_we = 1'b1; MEM_addr = 5'd7; MEM_wdata = 32'h1234_5678;
    push_cmd(t, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    step(); MEM_we = 1'b0;
    push_cmd(t + 1, 1'b0, 1'b0, 5'd7, '0);
    push_m(t + 4, 32'h1234_5678);
    step(); MEM_req = 1'b0;
    repeat (4) step();
    check("f_rdata_hold", 64'(F_rdata), 64'h0000_0000_C0DE_000B);
    check("mem_rdata_hold", 64'(MEM_rdata), 64'h0000_0000_1234_5678);

    // Reset mid-BUSY: read abandoned, new F request granted right after release
    step(); t = cyc;
    F_req = 1'b1; F_addr = 5'd4;
    push_cmd(t, 1'b1, 1'b0, 5'd4, '0);
    step(); F_req = 1'b0;
    #1 rst = 1'b1;
    step(); F_req = 1'b1; F_addr = 5'd6;
    step();
    step(); rst = 1'b0;
    push_cmd(t + 4, 1'b1, 1'b0, 5'd6, '0);
    push_f(t + 7, 32'hC0DE_0006);
    step(); F_req = 1'b0;
    repeat (4) step();

    // Requests held during BUSY: starve_cnt must not advance while BUSY
    step(); t = cyc;
    F_req = 1'b1; F_addr = 5'd13;
    MEM_req = 1'b1; MEM_we = 1'b0; MEM_addr = 5'd12;
    push_cmd(t, 1'b0, 1'b0, 5'd12, '0);
    push_m(t + 3, 32'hC0DE_000C);
    step(); MEM_addr = 5'd14;
    step(); step();
    push_cmd(t + 3, 1'b0, 1'b0, 5'd14, '0);
    push_m(t + 6, 32'hC0DE_000E);
    step(); MEM_we = 1'b1; MEM_addr = 5'd15; MEM_wdata = 32'h6000_0015;
    step(); step();
    push_cmd(t + 6, 1'b0, 1'b1, 5'd15, 32'h6000_0015);
    step(); MEM_addr = 5'd16; MEM_wdata = 32'h6000_0016;
    push_cmd(t + 7, 1'b1, 1'b0, 5'd13, '0);
    push_f(t + 10, 32'hC0DE_000D);
    push_cmd(t + 10, 1'b0, 1'b1, 5'd16, 32'h6000_0016);
    step(); F_req = 1'b0;
    step(); step();
    step(); MEM_req = 1'b0;
    repeat (3) step();

    check("cmd_queue_drained", 64'(exp_cmd.size()), 64'h0);
    check("f_queue_drained", 64'(exp_f.size()), 64'h0);
    check("mem_queue_drained", 64'(exp_m.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
